gnt_arbiter: RTL and testbench
==============================

# gnt_arbiter

Round-robin grant arbiter that shares the single downstream `gnt` channel between `N_REQ` requesters. It enforces the grant-width contract on the channel: no grant stays high longer than `MAX_HOLD` consecutive cycles, and each grant is followed by at least `GAP` idle cycles. The burst limit, the mandatory idle gap and rotating priority together make the channel deadlock- and starvation-free. `gnt_valid` drives the `gnt` input of the downstream block directly; it is a registered output, so no external sender flop is needed.

## Interface
- `N_REQ`, 4: number of requesters, ≥2.
- `MAX_HOLD`, 8: maximum consecutive cycles any grant is high, ≥1.
- `GAP`, 1: minimum cycles all grants are low between two grants, ≥1.
- `clk` in 1: single clock; all logic is on posedge.
- `reset` in 1: synchronous, active-high.
- `req` in `N_REQ`: level request per requester; it is held until served.
- `gnt` out `N_REQ`: one-hot-or-zero grant, registered.
- `gnt_valid` out 1: OR of `gnt`, registered; this is the channel `gnt`.
- `gnt_id` out `$clog2(N_REQ)`: index of the current owner; holds its last value when `gnt_valid`=0.
- `preempt` out 1: one-cycle pulse in the first low cycle after a forced (`MAX_HOLD`) release.

## Operation
- **States:** IDLE, GRANT, GAP.
- **IDLE:**
  - If `|req`, pick the winner and go to GRANT.
  - `gnt[win]`, `gnt_valid` and `gnt_id` are registered high next cycle.
  - `hold_cnt` is loaded with 1.
- **Winner selection:** round-robin. Search starts at `last_id+1` mod `N_REQ` and wraps; the first set `req` bit wins.
- **GRANT:** each cycle, evaluate `req[gnt_id]` and `hold_cnt`.
  - If `req[gnt_id]`=0, it is a voluntary release: go to GAP.
  - Else if `hold_cnt`==`MAX_HOLD`, it is a forced release: go to GAP and set `preempt` next cycle.
  - Else increment `hold_cnt`.
  - If both release conditions hold in the same cycle, treat it as voluntary (no `preempt`).
- **On every release:**
  - `last_id <= gnt_id`.
  - `gap_cnt` is loaded with 1.
  - All `gnt` bits go low next cycle.
- **GAP:**
  - While `gap_cnt` < `GAP`, increment.
  - When `gap_cnt`==`GAP`: if `|req`, arbitrate exactly as in IDLE and go to GRANT; else go to IDLE.
- **Priority rotation:** the previous owner gets lowest priority. If it is the only requester, it is re-granted after the gap.
- **Request drops:** a requester dropping `req` while not owner has no effect. `req` of other requesters during GRANT is ignored until arbitration.
- **Counter widths:** `hold_cnt` is `$clog2(MAX_HOLD+1)` bits and `gap_cnt` is `$clog2(GAP+1)` bits. Neither ever exceeds its limit; no wrap occurs.
- **Reset values:**
  - State IDLE.
  - `gnt`=0, `gnt_valid`=0, `gnt_id`=0, `preempt`=0.
  - `last_id`=`N_REQ-1`, so `req[0]` has top priority first.
  - `hold_cnt`=0, `gap_cnt`=0.
- **Reset mid-operation:** reset asserted at edge t means every output is at its reset value from t+1, regardless of state. Arbitration resumes on the first non-reset edge.

## Timing
- **Grant latency:** `req` first sampled high in IDLE at edge t gives `gnt` high in cycle t+1.
- **Maximum grant width:** exactly `MAX_HOLD` cycles high. With `MAX_HOLD`=8, `gnt_valid` is high cycles t+1..t+8 and low at t+9.
- **Voluntary release:** owner `req` sampled low at edge u gives `gnt` low in cycle u+1.
- **Gap length:** minimum low time between grants is exactly `GAP` cycles. Arbitration happens at the last gap edge, so a waiting requester sees `gnt` high in cycle GAP+1 after release.
- **Worst-case wait** for any requester: (`N_REQ`-1)·(`MAX_HOLD`+`GAP`)+`GAP`+1 cycles.
- **`preempt`:** coincides with the first low cycle of `gnt_valid` after a forced release.
- **Invariants:**
  - `gnt_valid` never high more than `MAX_HOLD` consecutive cycles.
  - `gnt` always one-hot-or-zero.

## Structure
- **Package `deadlock_pkg`:**
  - state enum `arb_state_e` {IDLE, GRANT, GAP};
  - default constants `GNT_MAX_HOLD`=8 and `GNT_GAP`=1, shared with the downstream checker properties.
- **Sub-module `gnt_rr_pick`:**
  - combinational rotating priority picker;
  - inputs `req`, `last_id`; outputs `win_id`, `win_valid`;
  - parameterized by `N_REQ`.
- **Top module:** FSM, `hold_cnt`/`gap_cnt`, `last_id` and output registers.

## Test plan
- **Single continuous requester:** `req`=4'b0001 held → `gnt`[0] high cycles 1–8, low cycle 9 with `preempt`=1, high again cycles 10–17 (`GAP`=1).
- **Voluntary release:** `req`[2] held 3 cycles then dropped → `gnt`[2] high exactly 3 cycles, `preempt`=0, `gnt_id`=2.
- **Round-robin:** `req`=4'b1111 held → grant order 0,1,2,3,0; each 8 cycles high, 1 cycle low.
- **Rotation skip:** owner 1 releases while `req`=4'b1001 → next grant is 3 (search starts at 2), then 0.
- **Simultaneous release conditions:** owner drops `req` in the same cycle `hold_cnt`=8 → `gnt` low next cycle with `preempt`=0.
- **Reset mid-grant:** reset at cycle 4 of a grant → cycle 5 has all outputs 0; after reset, `req`=4'b1010 → `gnt`[1] first. Throughout, formal/SVA checks the width ≤8 and gap ≥1 properties.

Source files
------------

// File: rtl/deadlock_pkg.sv
// Shared definitions for the grant-channel arbiter and its downstream checkers.
// Holds the FSM state type and the default grant-width contract limits.
package deadlock_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_GAP   = 2'd2
    } arb_state_e;

    localparam int GNT_MAX_HOLD = 8;
    localparam int GNT_GAP      = 1;

endpackage

// File: rtl/gnt_rr_pick.sv
// Combinational rotating-priority picker: the search starts one past last_id
// and wraps, so the previous owner is considered last.
module gnt_rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_id,
    output logic [$clog2(N_REQ)-1:0] win_id,
    output logic                     win_valid
);

    localparam int IW = $clog2(N_REQ);

    // Walk from the farthest offset down so the nearest set bit wins.
    always_comb begin
        int idx;
        win_valid = 1'b0;
        win_id    = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = (int'(last_id) + i) % N_REQ;
            if (req[idx]) begin
                win_valid = 1'b1;
                win_id    = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/gnt_arbiter.sv
// Round-robin arbiter for a shared gnt channel with a burst limit (MAX_HOLD)
// and a mandatory idle gap (GAP) between consecutive grants.
module gnt_arbiter
    import deadlock_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = GNT_MAX_HOLD,
    parameter int GAP      = GNT_GAP
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic                     gnt_valid,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     preempt
);

    localparam int IW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int GW = $clog2(GAP + 1);

    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [GW-1:0] GAP_MAX  = GW'(GAP);
    localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

    arb_state_e       state_q, state_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [IW-1:0]    last_id_q, last_id_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [IW-1:0]    gnt_id_q, gnt_id_d;
    logic             preempt_q, preempt_d;

    logic [IW-1:0]    win_id;
    logic             win_valid;
    logic             take;
    logic             release_now;

    gnt_rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .req      (req),
        .last_id  (last_id_q),
        .win_id   (win_id),
        .win_valid(win_valid)
    );

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        last_id_d   = last_id_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        preempt_d   = 1'b0;
        take        = 1'b0;
        release_now = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                take = win_valid;
            end
            ARB_GRANT: begin
                // A dropped request wins over the hold limit: no preempt then.
                if (!req[gnt_id_q]) begin
                    release_now = 1'b1;
                end else if (hold_cnt_q == HOLD_MAX) begin
                    release_now = 1'b1;
                    preempt_d   = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ARB_GAP: begin
                if (gap_cnt_q != GAP_MAX) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end else if (win_valid) begin
                    take = 1'b1;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (release_now) begin
            state_d     = ARB_GAP;
            last_id_d   = gnt_id_q;
            gap_cnt_d   = GW'(1);
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
        end

        if (take) begin
            state_d         = ARB_GRANT;
            gnt_d           = '0;
            gnt_d[win_id]   = 1'b1;
            gnt_valid_d     = 1'b1;
            gnt_id_d        = win_id;
            hold_cnt_d      = HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            hold_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            last_id_q   <= LAST_RST;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            last_id_q   <= last_id_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            preempt_q   <= preempt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_gnt_arbiter.sv
// Bench for gnt_arbiter: directed vector table plus randomized requests
// checked cycle by cycle against a waveform-level reference model.
module tb_gnt_arbiter;

    localparam int N  = 4;
    localparam int MH = 8;
    localparam int GP = 1;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic         preempt;

    gnt_arbiter #(
        .N_REQ   (N),
        .MAX_HOLD(MH),
        .GAP     (GP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .gnt      (gnt),
        .gnt_valid(gnt_valid),
        .gnt_id   (gnt_id),
        .preempt  (preempt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic       v;
        logic [1:0] id;
        logic       pre;
    } vec_t;

    vec_t tbl[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: owner (-1 = channel idle), length of the current
    // high run, length of the current low run, previous owner.
    int m_owner, m_hi, m_lo, m_last, m_id;
    bit m_pre;

    function automatic void add(bit r, logic [3:0] q, int own, int id, bit pre);
        vec_t e;
        e.rst = r;
        e.req = q;
        e.gnt = (own >= 0) ? 4'(1 << own) : 4'b0000;
        e.v   = (own >= 0);
        e.id  = 2'(id);
        e.pre = pre;
        tbl.push_back(e);
    endfunction

    task automatic model_step(bit r, logic [3:0] q);
        m_pre = 1'b0;
        if (r) begin
            m_owner = -1;
            m_hi    = 0;
            m_lo    = GP;
            m_last  = N - 1;
            m_id    = 0;
        end else if (m_owner >= 0) begin
            if (!q[m_owner] || m_hi == MH) begin
                m_pre   = q[m_owner];
                m_last  = m_owner;
                m_owner = -1;
                m_lo    = 1;
            end else begin
                m_hi++;
            end
        end else if (m_lo >= GP && q != 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (m_owner < 0 && q[c]) begin
                    m_owner = c;
                    m_id    = c;
                    m_hi    = 1;
                end
            end
        end else if (m_lo < 1000) begin
            m_lo++;
        end
    endtask

    task automatic apply(bit r, logic [3:0] q);
        reset = r;
        req   = q;
        @(posedge clk);
        model_step(r, q);
        #1;
    endtask

    task automatic check(string name, logic [3:0] eg, logic ev,
                         logic [1:0] eid, logic ep);
        vectors++;
        if (gnt !== eg || gnt_valid !== ev || gnt_id !== eid || preempt !== ep) begin
            miscompares++;
            $display("FAIL %s: got gnt=%b v=%b id=%0d pre=%b, want gnt=%b v=%b id=%0d pre=%b",
                     name, gnt, gnt_valid, gnt_id, preempt, eg, ev, eid, ep);
        end
    endtask

    initial begin
        logic [3:0] rq;
        logic [3:0] eg;
        bit         r;

        reset = 1'b1;
        req   = '0;

        // Single continuous requester: forced release every 8 cycles.
        add(1, 4'b0000, -1, 0, 0);
        for (int k = 1; k <= 18; k++) begin
            if (k == 9 || k == 18) add(0, 4'b0001, -1, 0, 1);
            else                   add(0, 4'b0001, 0, 0, 0);
        end
        // Voluntary release after 3 cycles.
        add(1, 4'b0000, -1, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 4'b0100, 2, 2, 0);
        add(0, 4'b0000, -1, 2, 0);
        add(0, 4'b0000, -1, 2, 0);
        // All four requesting: order 0,1,2,3,0.
        add(1, 4'b0000, -1, 0, 0);
        for (int k = 1; k <= 44; k++) begin
            int slot, pos;
            slot = (k - 1) / 9;
            pos  = (k - 1) % 9;
            if (pos == 8) add(0, 4'b1111, -1, slot % 4, 1);
            else          add(0, 4'b1111, slot % 4, slot % 4, 0);
        end
        // Rotation skip: owner 1 leaves with 3 and 0 waiting.
        add(1, 4'b0000, -1, 0, 0);
        add(0, 4'b0010, 1, 1, 0);
        add(0, 4'b1001, -1, 1, 0);
        add(0, 4'b1001, 3, 3, 0);
        add(0, 4'b0001, -1, 3, 0);
        add(0, 4'b0001, 0, 0, 0);
        // Drop coinciding with the hold limit counts as voluntary.
        add(1, 4'b0000, -1, 0, 0);
        for (int k = 0; k < 8; k++) add(0, 4'b0001, 0, 0, 0);
        add(0, 4'b0000, -1, 0, 0);
        // Reset in the middle of a grant, then 4'b1010 serves 1 first.
        add(1, 4'b0000, -1, 0, 0);
        for (int k = 0; k < 4; k++) add(0, 4'b0100, 2, 2, 0);
        add(1, 4'b0100, -1, 0, 0);
        add(0, 4'b1010, 1, 1, 0);

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].req);
            check($sformatf("tbl[%0d]", i), tbl[i].gnt, tbl[i].v,
                  tbl[i].id, tbl[i].pre);
        end

        // Randomized sticky requests with occasional resets.
        rq = '0;
        apply(1'b1, rq);
        check("rnd_reset", 4'b0000, 1'b0, 2'd0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
            end
            r = ($urandom_range(0, 299) == 0);
            apply(r, rq);
            eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
            check($sformatf("rnd[%0d]", c), eg, (m_owner >= 0),
                  2'(m_id), m_pre);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
